// File: rtl/tensor_core_pkg.sv
// Shared types and the saturation helper for the parametrised tensor core.
package tensor_core_pkg;

    typedef enum logic [1:0] {
        OP_MATMUL = 2'b00,
        OP_ADD    = 2'b01,
        OP_RELU   = 2'b10,
        OP_MAC    = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Working width for saturation; callers sign-extend into it and truncate back.
    localparam int SAT_W = 64;

    // Clamp a signed value into the range of a data_width-bit signed element.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] value,
        input int                      data_width
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/tensor_core_lane.sv
// One output element of the tensor core: picks row/col from the element
// index, evaluates the selected operation at full precision and saturates.
module tensor_core_lane
    import tensor_core_pkg::*;
#(
    parameter int DIM        = 3,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 4
) (
    input  logic [IDX_W-1:0]              index,
    input  logic [DIM*DIM*DATA_WIDTH-1:0] operand_a,
    input  logic [DIM*DIM*DATA_WIDTH-1:0] operand_b,
    input  logic [DIM*DIM*DATA_WIDTH-1:0] current,
    input  op_t                           op,
    output logic [DATA_WIDTH-1:0]         result
);

    localparam int NE        = DIM * DIM;
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(DIM) + 1;

    int                            elem;
    int                            row;
    int                            col;
    logic signed [DATA_WIDTH-1:0]  a_rc;
    logic signed [DATA_WIDTH-1:0]  b_rc;
    logic signed [DATA_WIDTH-1:0]  cur_rc;
    logic signed [DATA_WIDTH-1:0]  a_rk;
    logic signed [DATA_WIDTH-1:0]  b_kc;
    logic signed [ACC_WIDTH-1:0]   dot;
    logic signed [ACC_WIDTH-1:0]   acc;

    // Element arithmetic; disabled lanes (index past the matrix) fold onto element 0.
    always_comb begin
        elem   = (int'(index) < NE) ? int'(index) : 0;
        row    = elem / DIM;
        col    = elem % DIM;
        a_rc   = operand_a[elem*DATA_WIDTH +: DATA_WIDTH];
        b_rc   = operand_b[elem*DATA_WIDTH +: DATA_WIDTH];
        cur_rc = current[elem*DATA_WIDTH +: DATA_WIDTH];
        a_rk   = '0;
        b_kc   = '0;
        dot    = '0;
        for (int k = 0; k < DIM; k++) begin
            a_rk = operand_a[(row*DIM + k)*DATA_WIDTH +: DATA_WIDTH];
            b_kc = operand_b[(k*DIM + col)*DATA_WIDTH +: DATA_WIDTH];
            dot  = dot + ACC_WIDTH'(a_rk) * ACC_WIDTH'(b_kc);
        end
        case (op)
            OP_MATMUL: acc = dot;
            OP_ADD:    acc = ACC_WIDTH'(a_rc) + ACC_WIDTH'(b_rc);
            OP_RELU:   acc = a_rc[DATA_WIDTH-1] ? '0 : ACC_WIDTH'(a_rc);
            OP_MAC:    acc = dot + ACC_WIDTH'(cur_rc);
            default:   acc = dot;
        endcase
        result = DATA_WIDTH'(saturate(SAT_W'(acc), DATA_WIDTH));
    end

endmodule

// File: rtl/param_tensor_core.sv
// Parametrised DIM x DIM tensor core: sequences LANES output elements per
// cycle through tensor_core_lane instances into a registered result matrix.
//
// Handshake: should_start_tensor_core is a level sampled in IDLE or DONE; the
// edge that samples it high latches operation_select. busy is high for every
// RUN cycle, one group written per edge, and done is a single-cycle pulse in
// the cycle after the final group. Operands are read live, so the producer
// keeps them stable while busy. A register-file write aborts to IDLE with no done.
module param_tensor_core
    import tensor_core_pkg::*;
#(
    parameter int DIM        = 3,
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1
) (
    input  logic                          tensor_core_clock,
    input  logic                          reset_in,
    input  logic                          tensor_core_register_file_write_enable,
    input  logic                          should_start_tensor_core,
    input  logic [1:0]                    operation_select,
    input  logic [DIM*DIM*DATA_WIDTH-1:0] tensor_core_input1,
    input  logic [DIM*DIM*DATA_WIDTH-1:0] tensor_core_input2,
    output logic [DIM*DIM*DATA_WIDTH-1:0] tensor_core_output,
    output logic                          busy,
    output logic                          done,
    output state_t                        fsm_state
);

    localparam int NE    = DIM * DIM;
    localparam int C     = (NE + LANES - 1) / LANES;
    localparam int GRP_W = (C > 1) ? $clog2(C) : 1;
    localparam int IDX_W = $clog2(NE + LANES);

    state_t                  state;
    op_t                     op_q;
    logic [GRP_W-1:0]        grp;
    logic [IDX_W-1:0]        grp_base;
    logic [IDX_W-1:0]        lane_idx [LANES];
    logic [DATA_WIDTH-1:0]   lane_res [LANES];
    logic [LANES-1:0]        lane_en;

    assign fsm_state = state;
    assign grp_base  = IDX_W'(grp) * IDX_W'(LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = grp_base + IDX_W'(l);
        assign lane_en[l]  = lane_idx[l] < IDX_W'(NE);

        tensor_core_lane #(
            .DIM        (DIM),
            .DATA_WIDTH (DATA_WIDTH),
            .IDX_W      (IDX_W)
        ) u_lane (
            .index     (lane_idx[l]),
            .operand_a (tensor_core_input1),
            .operand_b (tensor_core_input2),
            .current   (tensor_core_output),
            .op        (op_q),
            .result    (lane_res[l])
        );
    end

    // Control FSM, group counter and result registers with abort/start priority.
    always_ff @(posedge tensor_core_clock) begin
        if (reset_in) begin
            state              <= ST_IDLE;
            op_q               <= OP_MATMUL;
            grp                <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            tensor_core_output <= '0;
        end else begin
            done <= 1'b0;
            if (tensor_core_register_file_write_enable) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (should_start_tensor_core) begin
                            state <= ST_RUN;
                            op_q  <= op_t'(operation_select);
                            grp   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        for (int l = 0; l < LANES; l++) begin
                            if (lane_en[l]) begin
                                tensor_core_output[int'(lane_idx[l])*DATA_WIDTH +: DATA_WIDTH] <= lane_res[l];
                            end
                        end
                        if (grp == GRP_W'(C - 1)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            grp <= grp + GRP_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (should_start_tensor_core) begin
                            state <= ST_RUN;
                            op_q  <= op_t'(operation_select);
                            grp   <= '0;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_param_tensor_core.sv
// Self-checking bench for param_tensor_core: a LANES=1 and a LANES=4 instance
// share operands; vectors come from a table, a small model and hand sequences.
module tb_param_tensor_core;
    import tensor_core_pkg::*;

    localparam int NE = 9;
    localparam int MW = 72;

    typedef struct {
        logic [1:0]    op;
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [MW-1:0] exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst1, rst4, we1, we4, start1, start4;
    logic [1:0]    op_sel;
    logic [MW-1:0] in_a, in_b, out1, out4;
    logic          busy1, busy4, done1, done4;
    state_t        st1, st4;

    param_tensor_core #(.DIM(3), .DATA_WIDTH(8), .LANES(1)) dut1 (
        .tensor_core_clock                      (clk),
        .reset_in                               (rst1),
        .tensor_core_register_file_write_enable (we1),
        .should_start_tensor_core               (start1),
        .operation_select                       (op_sel),
        .tensor_core_input1                     (in_a),
        .tensor_core_input2                     (in_b),
        .tensor_core_output                     (out1),
        .busy                                   (busy1),
        .done                                   (done1),
        .fsm_state                              (st1)
    );

    param_tensor_core #(.DIM(3), .DATA_WIDTH(8), .LANES(4)) dut4 (
        .tensor_core_clock                      (clk),
        .reset_in                               (rst4),
        .tensor_core_register_file_write_enable (we4),
        .should_start_tensor_core               (start4),
        .operation_select                       (op_sel),
        .tensor_core_input1                     (in_a),
        .tensor_core_input2                     (in_b),
        .tensor_core_output                     (out4),
        .busy                                   (busy4),
        .done                                   (done4),
        .fsm_state                              (st4)
    );

    // ---------------- scoreboard ----------------
    logic [MW-1:0] exp_q[$];
    logic [MW-1:0] last1, last4;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- matrix helpers and model ----------------
    function automatic logic [MW-1:0] m9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        int v[9];
        logic [MW-1:0] m;
        v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3; v[4] = e4;
        v[5] = e5; v[6] = e6; v[7] = e7; v[8] = e8;
        m = '0;
        for (int i = 0; i < NE; i++) m[i*8 +: 8] = 8'(v[i]);
        return m;
    endfunction

    function automatic logic [MW-1:0] fill(input int v);
        return m9(v, v, v, v, v, v, v, v, v);
    endfunction

    function automatic int el(input logic [MW-1:0] m, input int i);
        logic signed [7:0] t;
        t = m[i*8 +: 8];
        return int'(t);
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < NE; i++) m[i*8 +: 8] = 8'($urandom_range(0, 255));
        return m;
    endfunction

    function automatic logic [MW-1:0] model(input logic [1:0] op, input logic [MW-1:0] a, b, cur);
        logic [MW-1:0] res;
        int s, dotp;
        res = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                dotp = 0;
                for (int k = 0; k < 3; k++) dotp += el(a, r*3 + k) * el(b, k*3 + c);
                case (op)
                    2'b00:   s = dotp;
                    2'b01:   s = el(a, r*3 + c) + el(b, r*3 + c);
                    2'b10:   s = (el(a, r*3 + c) < 0) ? 0 : el(a, r*3 + c);
                    default: s = dotp + el(cur, r*3 + c);
                endcase
                if (s > 127) s = 127;
                if (s < -128) s = -128;
                res[(r*3 + c)*8 +: 8] = 8'(s);
            end
        end
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_start(input bit use4, input logic v);
        if (use4) start4 = v;
        else start1 = v;
    endtask

    function automatic logic [MW-1:0] out_of(input bit use4);
        return use4 ? out4 : out1;
    endfunction

    // Count cycles after the start edge until done (bounded); optional stray start in RUN.
    task automatic wait_done(input bit use4, input int extra, output int n, output int bc);
        n = 0;
        bc = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            set_start(use4, (extra > 0 && n == extra) ? 1'b1 : 1'b0);
            if (use4 ? done4 : done1) break;
            if (use4 ? busy4 : busy1) bc++;
        end
    endtask

    task automatic run_vec(input bit use4, input logic [1:0] op, input logic [MW-1:0] a, b, exp,
                           input string name, input int extra);
        int n, bc;
        logic [MW-1:0] want;
        @(negedge clk);
        op_sel = op;
        in_a   = a;
        in_b   = b;
        set_start(use4, 1'b1);
        exp_q.push_back(exp);
        if (use4) last4 = exp;
        else last1 = exp;
        @(posedge clk);
        #1;
        set_start(use4, 1'b0);
        wait_done(use4, extra, n, bc);
        check({name, "_latency"}, MW'(n), MW'(use4 ? 4 : 10));
        check({name, "_busy_cycles"}, MW'(bc), MW'(use4 ? 3 : 9));
        want = exp_q.pop_front();
        check({name, "_data"}, out_of(use4), want);
        @(negedge clk);
        check({name, "_after_done"}, MW'({use4 ? done4 : done1, use4 ? busy4 : busy1}), MW'(2'b00));
    endtask

    // ---------------- test ----------------
    vec_t tbl[9];
    logic [MW-1:0] ident, b9, abort_exp, want;
    int n, bc;
    logic saw_done;

    initial begin
        ident = m9(1, 0, 0, 0, 1, 0, 0, 0, 1);
        b9    = m9(1, 2, 3, 4, 5, 6, 7, 8, 9);
        tbl[0] = '{2'b00, ident,       b9,          b9};
        tbl[1] = '{2'b00, fill(100),   fill(100),   fill(127)};
        tbl[2] = '{2'b00, fill(-100),  fill(100),   fill(-128)};
        tbl[3] = '{2'b01, fill(100),   fill(100),   fill(127)};
        tbl[4] = '{2'b01, fill(-5),    fill(3),     fill(-2)};
        tbl[5] = '{2'b10, m9(-7, 7, -128, 0, -7, 7, -128, 0, 5), fill(99),
                   m9(0, 7, 0, 0, 0, 7, 0, 0, 5)};
        tbl[6] = '{2'b00, ident,       fill(1),     fill(1)};
        tbl[7] = '{2'b11, ident,       fill(1),     fill(2)};
        tbl[8] = '{2'b11, fill(127),   ident,       fill(127)};

        rst1 = 1'b1; rst4 = 1'b1; we1 = 1'b0; we4 = 1'b0;
        start1 = 1'b0; start4 = 1'b0; op_sel = 2'b00; in_a = '0; in_b = '0;
        last1 = '0; last4 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst1 = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        check("reset_out1", out1, '0);
        check("reset_out4", out4, '0);
        check("reset_flags1", MW'({busy1, done1}), MW'(2'b00));
        check("reset_flags4", MW'({busy4, done4}), MW'(2'b00));
        check("reset_state1", MW'(st1), MW'(ST_IDLE));

        for (int i = 0; i < 9; i++)
            run_vec(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("l1_tbl%0d", i), 0);
        for (int i = 0; i < 9; i++)
            run_vec(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("l4_tbl%0d", i), 0);

        for (int i = 0; i < 6; i++) begin
            logic [1:0] rop;
            logic [MW-1:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra = rand_mat();
            rb = rand_mat();
            run_vec(1'b0, rop, ra, rb, model(rop, ra, rb, last1), $sformatf("l1_rand%0d", i), 0);
        end
        for (int i = 0; i < 3; i++) begin
            logic [1:0] rop;
            logic [MW-1:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra = rand_mat();
            rb = rand_mat();
            run_vec(1'b1, rop, ra, rb, model(rop, ra, rb, last4), $sformatf("l4_rand%0d", i), 0);
        end

        // Start during RUN is ignored: latency and single done unchanged.
        run_vec(1'b0, 2'b01, fill(2), fill(3), fill(5), "start_in_run", 3);

        // Abort on the 5th RUN cycle: elements 0..3 written, 4..8 keep 5.
        run_vec(1'b0, 2'b01, fill(5), fill(0), fill(5), "pre_abort", 0);
        abort_exp = m9(1, 2, 3, 4, 5, 5, 5, 5, 5);
        @(negedge clk);
        op_sel = 2'b00; in_a = ident; in_b = b9; start1 = 1'b1;
        exp_q.push_back(abort_exp);
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1 we1 = 1'b1;
        @(posedge clk);
        #1 we1 = 1'b0;
        @(negedge clk);
        check("abort_busy", MW'(busy1), MW'(1'b0));
        check("abort_state", MW'(st1), MW'(ST_IDLE));
        saw_done = done1;
        repeat (3) begin
            @(negedge clk);
            saw_done = saw_done | done1;
        end
        check("abort_no_done", MW'(saw_done), MW'(1'b0));
        want = exp_q.pop_front();
        check("abort_data", out1, want);

        // Start together with a register-file write in IDLE is ignored.
        @(negedge clk);
        start1 = 1'b1; we1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; we1 = 1'b0;
        check("we_start_busy", MW'(busy1), MW'(1'b0));
        check("we_start_state", MW'(st1), MW'(ST_IDLE));
        repeat (2) @(negedge clk);
        check("we_start_data", out1, abort_exp);

        // Back-to-back: start held into DONE restarts immediately.
        @(negedge clk);
        op_sel = 2'b01; in_a = fill(1); in_b = fill(1); start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        wait_done(1'b0, 0, n, bc);
        check("b2b_first_latency", MW'(n), MW'(10));
        check("b2b_first_data", out1, fill(2));
        in_a = fill(3); in_b = fill(3); start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        @(negedge clk);
        check("b2b_restart", MW'({busy1, done1}), MW'(2'b10));
        wait_done(1'b0, 0, n, bc);
        check("b2b_second_latency", MW'(n), MW'(9));
        check("b2b_second_data", out1, fill(6));
        @(negedge clk);
        check("b2b_done_once", MW'(done1), MW'(1'b0));

        // Reset mid-run clears everything.
        @(negedge clk);
        op_sel = 2'b01; in_a = fill(4); in_b = fill(4); start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst1 = 1'b1;
        @(posedge clk);
        #1 rst1 = 1'b0;
        @(negedge clk);
        check("midreset_out", out1, '0);
        check("midreset_flags", MW'({busy1, done1}), MW'(2'b00));
        check("midreset_state", MW'(st1), MW'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
